// File: rtl/sspis_reg_bridge.sv
`timescale 1ns/1ps
// SPI mode-0 slave that turns command/address/data frames into single 32-bit
// register-bus reads and writes; every SPI input is resampled into mclk.
module sspis_reg_bridge #(
    parameter logic [7:0] CMD_WR = 8'h01,
    parameter logic [7:0] CMD_RD = 8'h02
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        sclk,
    input  logic        ssn,
    input  logic        sdin,
    output logic        sdout,
    output logic        sdout_oen,
    output logic        reg_cs,
    output logic        reg_wr,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic [3:0]  reg_be,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDUMMY, RDATA, IGNORE} state_t;
    state_t state, state_next;

    logic [1:0]  sclk_sync, ssn_sync, sdin_sync;
    logic        sclk_d, ssn_d;
    logic        sclk_rise, sclk_fall, ssn_rise, ssn_fall;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  byte_val;
    logic        byte_done;
    logic        op_wr, dummy_done;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  byte_cnt;
    logic [31:0] tx_sr;
    logic [4:0]  tx_cnt;
    logic        req_rd, req_wr, load_tx, shift_tx, end_tx;
    logic        pend, pend_wr, rd_live, rd_valid;
    logic [31:0] rd_hold;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= 2'b00;
            ssn_sync  <= 2'b11;
            sdin_sync <= 2'b00;
            sclk_d    <= 1'b0;
            ssn_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            ssn_sync  <= {ssn_sync[0], ssn};
            sdin_sync <= {sdin_sync[0], sdin};
            sclk_d    <= sclk_sync[1];
            ssn_d     <= ssn_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[1] & sclk_d;
    assign ssn_rise  = ssn_sync[1] & ~ssn_d;
    assign ssn_fall  = ~ssn_sync[1] & ssn_d;
    assign sdout_oen = ssn_sync[1];
    assign byte_val  = {shift_in, sdin_sync[1]};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_rd     = 1'b0;
        req_wr     = 1'b0;
        load_tx    = 1'b0;
        shift_tx   = 1'b0;
        end_tx     = 1'b0;
        if (ssn_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (ssn_fall) state_next = CMD;
                CMD:     if (byte_done)
                             state_next = (byte_val == CMD_WR || byte_val == CMD_RD) ? ADDR : IGNORE;
                ADDR:    if (byte_done) begin
                             state_next = op_wr ? WDATA : RDUMMY;
                             req_rd     = ~op_wr;
                         end
                WDATA:   if (byte_done && byte_cnt == 2'd3) begin
                             req_wr     = 1'b1;
                             state_next = IGNORE;
                         end
                RDUMMY:  if (sclk_fall && dummy_done) begin
                             load_tx    = 1'b1;
                             state_next = RDATA;
                         end
                RDATA:   if (sclk_fall) begin
                             if (tx_cnt == 5'd31) begin
                                 end_tx     = 1'b1;
                                 state_next = IGNORE;
                             end else begin
                                 shift_tx = 1'b1;
                             end
                         end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= 3'd0;
            shift_in   <= 7'd0;
            op_wr      <= 1'b0;
            addr_q     <= 8'd0;
            wdata_q    <= 32'd0;
            byte_cnt   <= 2'd0;
            dummy_done <= 1'b0;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift_in <= byte_val[6:0];
            end
            if (state == CMD && byte_done) op_wr <= (byte_val == CMD_WR);
            if (state == ADDR && byte_done) begin
                addr_q     <= byte_val;
                byte_cnt   <= 2'd0;
                dummy_done <= 1'b0;
            end
            if (state == WDATA && byte_done) begin
                wdata_q  <= {wdata_q[23:0], byte_val};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == RDUMMY && byte_done) dummy_done <= 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            tx_sr  <= 32'd0;
            tx_cnt <= 5'd0;
            sdout  <= 1'b0;
        end else if (load_tx) begin
            tx_sr  <= rd_valid ? rd_hold : 32'h0;
            sdout  <= rd_valid & rd_hold[31];
            tx_cnt <= 5'd0;
        end else if (shift_tx) begin
            tx_sr  <= {tx_sr[30:0], 1'b0};
            sdout  <= tx_sr[30];
            tx_cnt <= tx_cnt + 5'd1;
        end else if (end_tx || state != RDATA) begin
            sdout <= 1'b0;
        end
    end

    // Requests are parked in pend so a new frame never disturbs a bus cycle still in flight.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            reg_cs    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= 8'd0;
            reg_wdata <= 32'd0;
            reg_be    <= 4'h0;
            pend      <= 1'b0;
            pend_wr   <= 1'b0;
            rd_live   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_hold   <= 32'd0;
        end else begin
            if (reg_cs) begin
                if (reg_ack) begin
                    reg_cs  <= 1'b0;
                    reg_wr  <= 1'b0;
                    reg_be  <= 4'h0;
                    rd_live <= 1'b0;
                    if (rd_live) begin
                        rd_hold  <= reg_rdata;
                        rd_valid <= 1'b1;
                    end
                end
            end else if (pend) begin
                reg_cs    <= 1'b1;
                reg_wr    <= pend_wr;
                reg_addr  <= addr_q;
                reg_wdata <= wdata_q;
                reg_be    <= 4'hF;
                pend      <= 1'b0;
                rd_live   <= ~pend_wr;
            end
            if (load_tx || ssn_rise) rd_live <= 1'b0;
            if (req_rd) rd_valid <= 1'b0;
            if (req_rd || req_wr) begin
                pend    <= 1'b1;
                pend_wr <= req_wr;
            end
        end
    end
endmodule

// File: tb/tb_sspis_reg_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for sspis_reg_bridge: drives SPI frames as a mode-0 master
// and answers the register bus, comparing against a frame-level reference model.
module tb_sspis_reg_bridge;
    localparam int HP = 8;

    logic        mclk = 1'b0, reset_n = 1'b0, sclk = 1'b0, ssn = 1'b1, sdin = 1'b0;
    logic        sdout, sdout_oen, reg_cs, reg_wr, reg_ack;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic [3:0]  reg_be;

    int tests_run = 0, tests_failed = 0;
    int ack_delay = 2, cs_cycles = 0, cs_starts = 0, ack_count = 0;
    int cs_hold_err = 0, stable_err = 0;
    logic [31:0] rd_value = 32'h0;
    logic [44:0] snap;
    logic [7:0]  tx_bytes[8];
    logic [7:0]  rx_bytes[8];
    logic        log_wr[$];
    logic [7:0]  log_addr[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_be[$];

    sspis_reg_bridge dut (
        .mclk(mclk), .reset_n(reset_n), .sclk(sclk), .ssn(ssn), .sdin(sdin),
        .sdout(sdout), .sdout_oen(sdout_oen), .reg_cs(reg_cs), .reg_wr(reg_wr),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack)
    );

    always #5 mclk = ~mclk;

    // Register-bus responder: acks after ack_delay cycles, logs each transfer,
    // and counts hold/stability violations; rdata is garbage except in the ack cycle.
    initial begin
        reg_ack = 1'b0;
        reg_rdata = 32'h0;
        forever begin
            @(negedge mclk);
            reg_rdata = $urandom;
            if (reg_ack) begin
                reg_ack = 1'b0;
                if (reg_cs !== 1'b0) cs_hold_err++;
                cs_cycles = 0;
            end else if (reg_cs === 1'b1) begin
                if (cs_cycles == 0) begin
                    cs_starts++;
                    snap = {reg_wr, reg_addr, reg_wdata, reg_be};
                end else if ({reg_wr, reg_addr, reg_wdata, reg_be} !== snap) begin
                    stable_err++;
                end
                cs_cycles++;
                if (cs_cycles > ack_delay) begin
                    reg_ack = 1'b1;
                    reg_rdata = rd_value;
                    ack_count++;
                    log_wr.push_back(reg_wr);
                    log_addr.push_back(reg_addr);
                    log_data.push_back(reg_wdata);
                    log_be.push_back(reg_be);
                end
            end else begin
                cs_cycles = 0;
            end
        end
    end

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            sdin = tx[i];
            wait_clks(HP);
            rx[i] = sdout;
            sclk = 1'b1;
            wait_clks(HP);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input int n);
        logic [7:0] r;
        ssn = 1'b0;
        wait_clks(2 * HP);
        for (int b = 0; b < n; b++) begin
            spi_byte(tx_bytes[b], r);
            rx_bytes[b] = r;
        end
        wait_clks(HP);
        ssn = 1'b1;
        sdin = 1'b0;
        wait_clks(2 * HP);
    endtask

    task automatic wait_bus_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (reg_cs === 1'b0 && reg_ack === 1'b0) begin
                ok = 1'b1;
                break;
            end
            wait_clks(1);
        end
    endtask

    task automatic clear_log();
        log_wr.delete(); log_addr.delete(); log_data.delete(); log_be.delete();
    endtask

    // Frame-level model: a valid read needs cmd+addr, a write needs cmd+addr+4 data bytes;
    // read data survives only if the ack lands before the 8-bit dummy byte has elapsed.
    function automatic void model_frame(input int n, output bit has, output bit wr,
                                        output logic [7:0] addr, output logic [31:0] data,
                                        output logic [31:0] rdata);
        has = 1'b0; wr = 1'b0; addr = 8'h0; data = 32'h0; rdata = 32'h0;
        if (tx_bytes[0] == 8'h02 && n >= 2) begin
            has = 1'b1;
            addr = tx_bytes[1];
            rdata = (ack_delay + 8 < 16 * HP) ? rd_value : 32'h0;
        end else if (tx_bytes[0] == 8'h01 && n >= 6) begin
            has = 1'b1; wr = 1'b1;
            addr = tx_bytes[1];
            data = {tx_bytes[2], tx_bytes[3], tx_bytes[4], tx_bytes[5]};
        end
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        wait_clks(3);
        #1;
        tests_run++;
        if ({sdout, sdout_oen, reg_cs, reg_wr} !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0100", {sdout, sdout_oen, reg_cs, reg_wr});
        end
        tests_run++;
        if ({reg_addr, reg_wdata, reg_be} !== 44'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bus: got %h expected 0", {reg_addr, reg_wdata, reg_be});
        end
        reset_n = 1'b1;
        wait_clks(8);
        tests_run++;
        if ({sdout, sdout_oen, reg_cs} !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL post_reset: got %b expected 010", {sdout, sdout_oen, reg_cs});
        end
    endtask

    task automatic test_write();
        int s0, a0, h0, st0;
        bit ok;
        clear_log();
        ack_delay = 2;
        s0 = cs_starts; a0 = ack_count; h0 = cs_hold_err; st0 = stable_err;
        tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h10; tx_bytes[2] = 8'hDE;
        tx_bytes[3] = 8'hAD; tx_bytes[4] = 8'hBE; tx_bytes[5] = 8'hEF;
        spi_frame(6);
        wait_bus_idle(ok);
        tests_run++;
        if (!ok || cs_starts - s0 != 1 || ack_count - a0 != 1 || log_wr.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL write_count: got starts=%0d acks=%0d idle=%0d expected 1 1 1",
                     cs_starts - s0, ack_count - a0, ok);
        end else begin
            tests_run++;
            if ({log_wr[0], log_addr[0], log_data[0], log_be[0]} !== {1'b1, 8'h10, 32'hDEADBEEF, 4'hF}) begin
                tests_failed++;
                $display("[TB] FAIL write_fields: got wr=%b addr=%h data=%h be=%h expected 1 10 deadbeef f",
                         log_wr[0], log_addr[0], log_data[0], log_be[0]);
            end
        end
        tests_run++;
        if (cs_hold_err != h0 || stable_err != st0) begin
            tests_failed++;
            $display("[TB] FAIL write_handshake: got hold_err=%0d stable_err=%0d expected 0 0",
                     cs_hold_err - h0, stable_err - st0);
        end
    endtask

    task automatic test_read();
        bit ok;
        clear_log();
        ack_delay = 3;
        rd_value = 32'h12345678;
        tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h04; tx_bytes[2] = 8'h5A;
        for (int i = 3; i < 7; i++) tx_bytes[i] = 8'h00;
        spi_frame(7);
        wait_bus_idle(ok);
        tests_run++;
        if (!ok || log_wr.size() != 1 || log_wr[0] !== 1'b0 || log_addr[0] !== 8'h04 || log_be[0] !== 4'hF) begin
            tests_failed++;
            $display("[TB] FAIL read_bus: got n=%0d idle=%0d expected one read of addr 04", log_wr.size(), ok);
        end
        tests_run++;
        if ({rx_bytes[3], rx_bytes[4], rx_bytes[5], rx_bytes[6]} !== 32'h12345678) begin
            tests_failed++;
            $display("[TB] FAIL read_data: got %h expected 12345678",
                     {rx_bytes[3], rx_bytes[4], rx_bytes[5], rx_bytes[6]});
        end
        tests_run++;
        if ({rx_bytes[0], rx_bytes[1], rx_bytes[2]} !== 24'h0) begin
            tests_failed++;
            $display("[TB] FAIL read_preamble: got %h expected 000000", {rx_bytes[0], rx_bytes[1], rx_bytes[2]});
        end
    endtask

    task automatic test_late_read();
        bit ok, has, wr;
        logic [7:0] ea;
        logic [31:0] ed, er;
        clear_log();
        ack_delay = 300;
        rd_value = $urandom | 32'h8000_0001;
        tx_bytes[0] = 8'h02; tx_bytes[1] = 8'($urandom); tx_bytes[2] = 8'h00;
        for (int i = 3; i < 7; i++) tx_bytes[i] = 8'h00;
        model_frame(7, has, wr, ea, ed, er);
        spi_frame(7);
        wait_bus_idle(ok);
        tests_run++;
        if ({rx_bytes[3], rx_bytes[4], rx_bytes[5], rx_bytes[6]} !== er) begin
            tests_failed++;
            $display("[TB] FAIL late_data: got %h expected %h",
                     {rx_bytes[3], rx_bytes[4], rx_bytes[5], rx_bytes[6]}, er);
        end
        tests_run++;
        if (!ok || log_wr.size() != 1 || log_addr[0] !== ea) begin
            tests_failed++;
            $display("[TB] FAIL late_complete: got n=%0d idle=%0d expected 1 1", log_wr.size(), ok);
        end
        clear_log();
        ack_delay = 1;
        rd_value = 32'hCAFEF00D;
        tx_bytes[1] = 8'h20;
        spi_frame(7);
        wait_bus_idle(ok);
        tests_run++;
        if ({rx_bytes[3], rx_bytes[4], rx_bytes[5], rx_bytes[6]} !== 32'hCAFEF00D || log_addr.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL late_next: got %h expected cafef00d",
                     {rx_bytes[3], rx_bytes[4], rx_bytes[5], rx_bytes[6]});
        end
    endtask

    task automatic test_bad_cmd();
        int s0;
        bit ok;
        s0 = cs_starts;
        ack_delay = 1;
        tx_bytes[0] = 8'h55;
        for (int i = 1; i < 7; i++) tx_bytes[i] = 8'($urandom);
        spi_frame(7);
        wait_bus_idle(ok);
        tests_run++;
        if (cs_starts != s0) begin
            tests_failed++;
            $display("[TB] FAIL bad_cmd_bus: got %0d cycles expected 0", cs_starts - s0);
        end
        tests_run++;
        if ({rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3], rx_bytes[4], rx_bytes[5], rx_bytes[6]} !== 56'h0) begin
            tests_failed++;
            $display("[TB] FAIL bad_cmd_sdout: got %h expected 0",
                     {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3], rx_bytes[4], rx_bytes[5], rx_bytes[6]});
        end
    endtask

    task automatic test_abort_write();
        int s0;
        bit ok;
        logic [7:0] r;
        logic [7:0] ab[4];
        clear_log();
        ack_delay = 2;
        s0 = cs_starts;
        ab[0] = 8'h01; ab[1] = 8'h30; ab[2] = 8'hAA; ab[3] = 8'hBB;
        ssn = 1'b0;
        wait_clks(2 * HP);
        for (int b = 0; b < 4; b++) spi_byte(ab[b], r);
        tests_run++;
        if (sdout_oen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_oen: got %b expected 0", sdout_oen);
        end
        wait_clks(HP);
        ssn = 1'b1;
        wait_clks(4 * HP);
        tests_run++;
        if (cs_starts != s0) begin
            tests_failed++;
            $display("[TB] FAIL abort_nowrite: got %0d cycles expected 0", cs_starts - s0);
        end
        tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h08; tx_bytes[2] = 8'h00;
        tx_bytes[3] = 8'h00; tx_bytes[4] = 8'h00; tx_bytes[5] = 8'h01;
        spi_frame(6);
        wait_bus_idle(ok);
        tests_run++;
        if (!ok || log_wr.size() != 1 || {log_wr[0], log_addr[0], log_data[0]} !== {1'b1, 8'h08, 32'h1}) begin
            tests_failed++;
            $display("[TB] FAIL abort_next: got n=%0d expected one write 08 00000001", log_wr.size());
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        logic pre;
        clear_log();
        ack_delay = 2;
        rd_value = 32'hFFFFFFFF;
        tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h0C; tx_bytes[2] = 8'h00;
        for (int i = 3; i < 7; i++) tx_bytes[i] = 8'h00;
        fork
            spi_frame(7);
            begin
                wait_clks(2 * HP + 3 * 16 * HP + 150);
                #1;
                pre = sdout;
                reset_n = 1'b0;
                #1;
                tests_run++;
                if (pre !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL mid_read_sdout: got %b expected 1", pre);
                end
                tests_run++;
                if ({sdout, sdout_oen, reg_cs, reg_wr, reg_be} !== 8'b01000000) begin
                    tests_failed++;
                    $display("[TB] FAIL async_reset: got %b expected 01000000",
                             {sdout, sdout_oen, reg_cs, reg_wr, reg_be});
                end
            end
        join
        wait_clks(4);
        reset_n = 1'b1;
        wait_clks(8);
        clear_log();
        rd_value = 32'hA5C3_0F96;
        spi_frame(7);
        wait_bus_idle(ok);
        tests_run++;
        if ({rx_bytes[3], rx_bytes[4], rx_bytes[5], rx_bytes[6]} !== 32'hA5C30F96 || log_addr.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL reset_next_read: got %h expected a5c30f96",
                     {rx_bytes[3], rx_bytes[4], rx_bytes[5], rx_bytes[6]});
        end
    endtask

    task automatic test_random();
        int n, kind;
        bit ok, has, wr;
        logic [7:0] ea;
        logic [31:0] ed, er, got;
        for (int it = 0; it < 12; it++) begin
            clear_log();
            kind = $urandom_range(0, 2);
            ack_delay = $urandom_range(0, 6);
            rd_value = $urandom;
            for (int i = 0; i < 8; i++) tx_bytes[i] = 8'($urandom);
            if (kind == 0) begin
                tx_bytes[0] = 8'h01; n = 6;
            end else if (kind == 1) begin
                tx_bytes[0] = 8'h02; n = 7;
            end else begin
                while (tx_bytes[0] == 8'h01 || tx_bytes[0] == 8'h02) tx_bytes[0] = 8'($urandom);
                n = $urandom_range(2, 7);
            end
            model_frame(n, has, wr, ea, ed, er);
            spi_frame(n);
            wait_bus_idle(ok);
            tests_run++;
            if (!ok || log_wr.size() != int'(has)) begin
                tests_failed++;
                $display("[TB] FAIL rand_count[%0d]: got %0d transfers expected %0d", it, log_wr.size(), has);
            end else if (has) begin
                tests_run++;
                if ({log_wr[0], log_addr[0], log_be[0]} !== {wr, ea, 4'hF} || (wr && log_data[0] !== ed)) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_fields[%0d]: got wr=%b addr=%h data=%h expected %b %h %h",
                             it, log_wr[0], log_addr[0], log_data[0], wr, ea, ed);
                end
            end
            if (has && !wr) begin
                got = {rx_bytes[3], rx_bytes[4], rx_bytes[5], rx_bytes[6]};
                tests_run++;
                if (got !== er) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", it, got, er);
                end
            end else begin
                got = {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]};
                tests_run++;
                if (got !== 32'h0) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_sdout[%0d]: got %h expected 0", it, got);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_late_read();
        test_bad_cmd();
        test_abort_write();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/sspis_reg_bridge.md
Name: sspis_reg_bridge

Overview:
- Single-bit SPI slave (mode 0, MSB first) that lets an external SPI master initiate transactions on the internal 32-bit register bus.
- Acts as the register-bus initiator to register blocks such as the SPI master config block.
- Decodes a command byte, an address byte and data bytes, then issues one reg-bus write or read per SPI frame and returns the read data on sdout.
- All SPI inputs are synchronised into mclk; no logic is clocked by sclk.

Parameters:
- CMD_WR, 8'h01, command byte selecting a register write.
- CMD_RD, 8'h02, command byte selecting a register read.

Ports:
- mclk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low; clock mclk.
- sclk  input  1  SPI clock from the external master; must not exceed mclk/8.
- ssn  input  1  SPI slave select, active low.
- sdin  input  1  SPI serial data in (MOSI).
- sdout  output  1  SPI serial data out (MISO).
- sdout_oen  output  1  sdout output enable, active low; equals synchronised ssn.
- reg_cs  output  1  reg-bus chip select.
- reg_wr  output  1  reg-bus write (1) / read (0).
- reg_addr  output  8  reg-bus byte address.
- reg_wdata  output  32  reg-bus write data.
- reg_be  output  4  reg-bus byte enables; always 4'hF during a transfer.
- reg_rdata  input  32  reg-bus read data, valid with reg_ack.
- reg_ack  input  1  reg-bus acknowledge, single-cycle pulse.

Behaviour:
- Reset values: sdout=0, sdout_oen=1, reg_cs=0, reg_wr=0, reg_addr=0, reg_wdata=0, reg_be=0, FSM=IDLE, shift and bit counters=0.
- Synchronisation: sclk, ssn and sdin each pass through a 2-FF synchroniser.
  - sclk rise/fall are detected from the synchronised sclk and its delayed copy (one-cycle pulses).
  - Input-to-decision latency is 3 mclk cycles.
- SPI timing: sdin is sampled on the sclk rise pulse; sdout changes on the sclk fall pulse.
- Framing: bytes are assembled MSB first with a 3-bit bit counter; a byte completes on the 8th rise pulse.
- FSM states: IDLE, CMD, ADDR, WDATA, RDUMMY, RDATA, IGNORE.
  - IDLE -> CMD when ssn_sync falls; the bit counter clears.
  - CMD: at byte complete, CMD_WR or CMD_RD -> ADDR, storing the op; any other value -> IGNORE.
  - ADDR: at byte complete, reg_addr <= byte.
    - Write op -> WDATA with a 2-bit byte counter cleared.
    - Read op -> RDUMMY and start the bus read: reg_cs=1, reg_wr=0, reg_be=F.
  - WDATA: 4 bytes are packed big-endian (first byte -> reg_wdata[31:24]). After the 4th byte, start the bus write (reg_cs=1, reg_wr=1, reg_be=F) and go to IGNORE.
  - RDUMMY: 8 sclk bits are ignored (turnaround).
    - On the fall pulse after the 8th rise, load the 32-bit tx shift register, drive sdout=bit31 and go to RDATA.
    - The load value is the captured read data, or 32'h0 if reg_ack has not yet arrived.
  - RDATA: each fall pulse shifts left and drives the next bit. After 32 bits, sdout=0 and the FSM goes to IGNORE.
  - IGNORE: all sclk activity is ignored until ssn rises.
  - In any state, ssn_sync rising -> IDLE.
- Reg-bus handshake:
  - reg_cs, reg_wr, reg_addr, reg_wdata and reg_be are held stable while reg_cs=1.
  - reg_cs clears on the mclk edge following the cycle in which reg_ack=1, so no second ack is generated.
  - reg_be returns to 0 with reg_cs.
  - On a read, reg_rdata is captured into the read-data holding register in the reg_ack cycle.
  - A late ack (after the RDATA load) completes the bus cycle, but the data is discarded.
- Abort (ssn rises mid-frame):
  - In WDATA before the 4th byte: no bus write is issued.
  - An in-flight bus cycle (reg_cs=1) is never aborted; it completes on reg_ack while the FSM already returns to IDLE.
  - A new frame is accepted, but a new bus cycle is not started until reg_cs=0; the start waits at byte completion.
- sdout is 0 outside RDATA.
- Extra sclk pulses in a frame beyond the defined length have no effect.

Test Plan:
- Write frame 01,10,DE,AD,BE,EF with ack after 2 cycles -> one reg_cs pulse with reg_wr=1, addr=8'h10, wdata=32'hDEADBEEF, be=F; reg_cs drops the cycle after ack; exactly one ack consumed.
- Read frame 02,04,dummy,32 clocks with reg_rdata=32'h12345678 and ack after 3 cycles -> reg_wr=0, addr=8'h04; sdout bits on fall edges = 0x12345678 MSB first.
- Read with ack delayed beyond the dummy byte -> sdout shifts 32'h0; bus cycle still completes; the next frame operates normally.
- Command byte 8'h55 -> no reg_cs activity; sdout stays 0 for the whole frame.
- ssn deasserted after 2 write-data bytes -> no bus write; the following full write frame to addr 8'h08 with 32'h00000001 is issued correctly.
- Reset asserted mid-RDATA -> all outputs return to reset values immediately (sdout=0, sdout_oen=1, reg_cs=0); a subsequent read frame works.
